vppm_tx: RTL and testbench



---
 rtl/vppm_pkg.sv | 13 +
 rtl/vppm_pulse_gen.sv | 59 +++++
 rtl/vppm_tx.sv | 118 +++++++++++
 tb/tb_vppm_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vppm_pkg.sv
// Shared types and constants for the VPPM transmitter.
package vppm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } vppm_state_t;

    localparam int   BYTE_W        = 8;
    localparam logic PRE_START_BIT = 1'b1;

endpackage

// File: rtl/vppm_pulse_gen.sv
// Symbol timer and LED pulse generator: one pulse per symbol, width set by dim,
// position (start/end of symbol) set by the current bit.
module vppm_pulse_gen #(
    parameter int SYM_LEN = 100,
    parameter int SCW     = 8,
    parameter int NBD     = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NBD-1:0] dim,
    input  logic           sym_bit,
    output logic           led_out,
    output logic           boundary
);

    localparam logic [SCW-1:0] SC_LAST   = SCW'(SYM_LEN - 1);
    localparam logic [SCW:0]   SYM_LEN_W = (SCW + 1)'(SYM_LEN);

    logic [SCW-1:0]     sc;
    logic [SCW-1:0]     w_q;
    logic [NBD+SCW-1:0] prod;
    logic [SCW-1:0]     w_next;
    logic               on;

    assign boundary = (sc == SC_LAST);

    // Full-width product so the shift sees every bit before scaling down.
    always_comb begin
        prod   = (NBD + SCW)'(dim) * (NBD + SCW)'(SYM_LEN);
        w_next = SCW'(prod >> NBD);
    end

    // Bit 0 pulses at the start of the symbol, bit 1 at the end.
    always_comb begin
        if (sym_bit)
            on = ({1'b0, sc} >= (SYM_LEN_W - {1'b0, w_q}));
        else
            on = (sc < w_q);
    end

    // Free-running symbol counter; width is latched only at the boundary so a
    // mid-symbol dim change cannot disturb the symbol in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc      <= '0;
            w_q     <= '0;
            led_out <= 1'b0;
        end else begin
            led_out <= on;
            if (boundary) begin
                sc  <= '0;
                w_q <= w_next;
            end else begin
                sc <= sc + SCW'(1);
            end
        end
    end

endmodule

// File: rtl/vppm_tx.sv
// VPPM transmitter top: framing FSM (idle / preamble / data), byte shifter
// and valid/ready handshake around the pulse generator.
//
// state       | meaning
// ST_IDLE     | idle pattern (bit 0 pulses), accepts a byte at each boundary
// ST_PREAMBLE | PRE_SYMS alternating symbols starting with 1
// ST_DATA     | 8 data symbols MSB first, may chain the next byte at bit 7
import vppm_pkg::*;

module vppm_tx #(
    parameter int SYM_LEN  = 100,
    parameter int SCW      = 8,
    parameter int NBD      = 8,
    parameter int PRE_SYMS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NBD-1:0]    dim,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              led_out,
    output logic              busy,
    output logic              sym_strobe
);

    localparam int PCW = (PRE_SYMS > 1) ? $clog2(PRE_SYMS) : 1;
    localparam int BCW = $clog2(BYTE_W);
    localparam logic [PCW-1:0] PRE_LAST = PCW'(PRE_SYMS - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(BYTE_W - 1);

    vppm_state_t       state;
    logic [BYTE_W-1:0] shreg;
    logic [PCW-1:0]    pcnt;
    logic [BCW-1:0]    bcnt;
    logic              boundary;
    logic              sym_bit;
    logic              accept;

    vppm_pulse_gen #(
        .SYM_LEN (SYM_LEN),
        .SCW     (SCW),
        .NBD     (NBD)
    ) u_pulse (
        .clk      (clk),
        .rst      (rst),
        .dim      (dim),
        .sym_bit  (sym_bit),
        .led_out  (led_out),
        .boundary (boundary)
    );

    // Bit carried by the symbol currently being emitted.
    always_comb begin
        sym_bit = 1'b0;
        case (state)
            ST_PREAMBLE: sym_bit = PRE_START_BIT ^ pcnt[0];
            ST_DATA:     sym_bit = shreg[BYTE_W-1];
            default:     sym_bit = 1'b0;
        endcase
    end

    assign sym_strobe = boundary;
    assign in_ready   = boundary &&
                        ((state == ST_IDLE) || ((state == ST_DATA) && (bcnt == BIT_LAST)));
    assign accept     = in_valid && in_ready;

    // Framing FSM; everything advances only on symbol boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            pcnt  <= '0;
            bcnt  <= '0;
            busy  <= 1'b0;
        end else if (boundary) begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg <= in_data;
                        pcnt  <= '0;
                        busy  <= 1'b1;
                        state <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (pcnt == PRE_LAST) begin
                        pcnt  <= '0;
                        bcnt  <= '0;
                        state <= ST_DATA;
                    end else begin
                        pcnt <= pcnt + PCW'(1);
                    end
                end
                ST_DATA: begin
                    if (bcnt == BIT_LAST) begin
                        bcnt <= '0;
                        if (accept) begin
                            shreg <= in_data;
                        end else begin
                            shreg <= {shreg[BYTE_W-2:0], 1'b0};
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        shreg <= {shreg[BYTE_W-2:0], 1'b0};
                        bcnt  <= bcnt + BCW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vppm_tx.sv
// Self-checking bench for vppm_tx: symbol-level reference model plus
// table-driven width checks and directed framing/reset sequences.
module tb_vppm_tx;

    localparam int SYM_LEN  = 100;
    localparam int SCW      = 8;
    localparam int NBD      = 8;
    localparam int PRE_SYMS = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dim = 8'd128;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       led_out;
    logic       busy;
    logic       sym_strobe;

    int total = 0;
    int bad   = 0;
    int busy_cnt = 0;

    vppm_tx #(
        .SYM_LEN  (SYM_LEN),
        .SCW      (SCW),
        .NBD      (NBD),
        .PRE_SYMS (PRE_SYMS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dim        (dim),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .led_out    (led_out),
        .busy       (busy),
        .sym_strobe (sym_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: one symbol at a time, with the bits still to send kept
    // in a queue (preamble + byte pushed on acceptance).
    int   m_pos  = 0;
    int   m_w    = 0;
    bit   m_bit  = 0;
    bit   m_busy = 0;
    bit   m_led  = 0;
    bit   m_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos = 0; m_w = 0; m_bit = 0; m_busy = 0; m_led = 0;
            m_q.delete();
        end else begin
            if (m_bit) m_led = (m_pos >= SYM_LEN - m_w);
            else       m_led = (m_pos < m_w);
            if (m_pos == SYM_LEN - 1) begin
                if (in_valid && m_q.size() == 0) begin
                    if (!m_busy)
                        for (int i = 0; i < PRE_SYMS; i++) m_q.push_back((i % 2) == 0);
                    for (int i = 7; i >= 0; i--) m_q.push_back(in_data[i]);
                end
                if (m_q.size() > 0) begin
                    m_bit  = m_q.pop_front();
                    m_busy = 1;
                end else begin
                    m_bit  = 0;
                    m_busy = 0;
                end
                m_w   = (int'(dim) * SYM_LEN) >> NBD;
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        check("led_out",    int'(led_out),    int'(m_led));
        check("busy",       int'(busy),       int'(m_busy));
        check("sym_strobe", int'(sym_strobe), int'(m_pos == SYM_LEN - 1));
        check("in_ready",   int'(in_ready),   int'((m_pos == SYM_LEN - 1) && (m_q.size() == 0)));
        if (busy) busy_cnt++;
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Pulse length of the symbol following the next boundary.
    task automatic measure_next(output int hi);
        int k;
        hi = 0;
        k = 0;
        while (!sym_strobe && k < 2 * SYM_LEN) begin
            @(negedge clk);
            k++;
        end
        check("strobe_timeout", int'(sym_strobe), 1);
        @(negedge clk);
        for (int i = 0; i < SYM_LEN; i++) begin
            @(negedge clk);
            if (led_out) hi++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (!in_ready && k < 40 * SYM_LEN) begin
            @(negedge clk);
            k++;
        end
        check("ready_timeout", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0] dim_v;
        int         exp_w;
    } wvec_t;

    initial begin
        wvec_t vt[7];
        int    hi;
        int    hi2;
        bit    acc;

        vt[0] = '{8'd128, 50};
        vt[1] = '{8'd0,   0};
        vt[2] = '{8'd255, 99};
        vt[3] = '{8'd64,  25};
        vt[4] = '{8'd1,   0};
        vt[5] = '{8'd3,   1};
        vt[6] = '{8'd200, 78};

        wait_cycles(3);
        check("rst_led",   int'(led_out),    0);
        check("rst_busy",  int'(busy),       0);
        check("rst_ready", int'(in_ready),   0);
        check("rst_strb",  int'(sym_strobe), 0);
        rst = 1'b0;

        // Idle pulse widths over a table of dim values.
        for (int v = 0; v < 7; v++) begin
            dim = vt[v].dim_v;
            measure_next(hi);
            check("idle_width", hi, vt[v].exp_w);
        end

        // Mid-symbol dim change keeps the current width.
        dim = 8'd128;
        measure_next(hi);
        hi = 0;
        hi2 = 0;
        for (int i = 1; i <= SYM_LEN; i++) begin
            @(negedge clk);
            if (i == 20) dim = 8'd64;
            if (led_out) hi++;
        end
        for (int i = 0; i < SYM_LEN; i++) begin
            @(negedge clk);
            if (led_out) hi2++;
        end
        check("dim_change_cur",  hi,  50);
        check("dim_change_next", hi2, 25);

        // Single byte 0xA5: one preamble + 8 data symbols.
        dim = 8'd128;
        wait_cycles(2 * SYM_LEN);
        busy_cnt = 0;
        send_byte(8'hA5);
        wait_cycles(20 * SYM_LEN);
        check("busy_a5", busy_cnt, (PRE_SYMS + 8) * SYM_LEN);

        // 0x00 then 0xFF with valid held: one preamble, 16 data symbols.
        busy_cnt = 0;
        in_valid = 1'b1;
        in_data  = 8'h00;
        send_byte(8'h00);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        send_byte(8'hFF);
        wait_cycles(30 * SYM_LEN);
        check("busy_b2b", busy_cnt, (PRE_SYMS + 16) * SYM_LEN);

        // Reset during data bit 3 aborts the frame immediately.
        send_byte(8'hA5);
        wait_cycles((PRE_SYMS + 3) * SYM_LEN + 10);
        check("pre_rst_busy", int'(busy), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_led",   int'(led_out),  0);
        check("async_rst_busy",  int'(busy),     0);
        check("async_rst_ready", int'(in_ready), 0);
        wait_cycles(2);
        rst = 1'b0;
        busy_cnt = 0;
        wait_cycles(10 * SYM_LEN);
        check("post_rst_busy", busy_cnt, 0);

        // Random traffic and dim changes against the model.
        acc = 0;
        for (int c = 0; c < 40000; c++) begin
            @(negedge clk);
            if (acc) begin
                in_valid = ($urandom_range(0, 2) == 0);
                in_data  = 8'($urandom);
            end else if (!in_valid && $urandom_range(0, 299) == 0) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
            end
            if ($urandom_range(0, 399) == 0) dim = 8'($urandom);
            acc = in_valid && in_ready;
        end
        in_valid = 1'b0;
        wait_cycles(30 * SYM_LEN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
